// File: rtl/seq_div16.sv
// seq_div16: 16-bit sequential restoring divider (one quotient bit per clock).
//
// A request is accepted only in IDLE. A non-zero divisor takes 16 RUN cycles
// and then spends one cycle in DONE with done high. A zero divisor goes
// straight to DONE with the fixed divide-by-zero result.
//
// Results are registered on entry to DONE. They stay stable until the next
// request is accepted.
//
// Optional feature macro: SEQ_DIV_SIGNED_EN
//   defined   -> is_signed=1 selects two's-complement division. The operands
//                are turned into magnitudes at capture time, and the signs are
//                applied again when the result is registered.
//   undefined -> is_signed is ignored, division is unsigned only, and ovfl
//                stays 0. The port list is identical in both builds.

module seq_div16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             ovfl
);

    localparam int                CNT_W     = 5;
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]  ALL_ONES  = '1;
    localparam logic [WIDTH-1:0]  MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_divMag;
    logic               r_negQuo;
    logic               r_negRem;
    logic               r_ovflPend;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_divByZero;
    logic               r_ovfl;

    logic               w_dividendNeg;
    logic               w_divisorNeg;
    logic [WIDTH-1:0]   w_dividendMag;
    logic [WIDTH-1:0]   w_divisorMag;
    logic               w_overflowCase;
    logic               w_divisorZero;

    logic [WIDTH:0]     w_shiftRem;
    logic [WIDTH+1:0]   w_trial;
    logic               w_trialOk;
    logic [WIDTH-1:0]   w_stepRem;
    logic [WIDTH-1:0]   w_stepQuo;
    logic [WIDTH-1:0]   w_finalQuo;
    logic [WIDTH-1:0]   w_finalRem;
    logic               w_unusedTrialBit;

    // Operand preparation. The core always divides magnitudes. In signed mode
    // the operand signs are remembered here so the result can be fixed up.
`ifdef SEQ_DIV_SIGNED_EN
    assign w_dividendNeg  = is_signed & dividend[WIDTH-1];
    assign w_divisorNeg   = is_signed & divisor[WIDTH-1];
    assign w_dividendMag  = w_dividendNeg ? -dividend : dividend;
    assign w_divisorMag   = w_divisorNeg  ? -divisor  : divisor;
    // The most-negative value divided by -1 cannot be represented. The
    // magnitude path already yields MOST_NEG with a zero remainder, so the
    // only extra work is raising the flag.
    assign w_overflowCase = is_signed & (dividend == MOST_NEG) & (divisor == ALL_ONES);
`else
    logic w_unusedSigned;

    assign w_unusedSigned = is_signed;
    assign w_dividendNeg  = 1'b0;
    assign w_divisorNeg   = 1'b0;
    assign w_dividendMag  = dividend;
    assign w_divisorMag   = divisor;
    assign w_overflowCase = 1'b0;
`endif

    assign w_divisorZero = (divisor == '0);

    // One restoring step. Shift {rem,quo} left by one, then try subtracting
    // the divisor magnitude from the widened remainder. The extra top bit of
    // w_trial acts as the borrow (sign) bit. Whichever remainder is kept is
    // always below the divisor, so it fits back into WIDTH bits.
    assign w_shiftRem       = {r_rem, r_quo[WIDTH-1]};
    assign w_trial          = {1'b0, w_shiftRem} - {2'b00, r_divMag};
    assign w_trialOk        = ~w_trial[WIDTH+1];
    assign w_stepRem        = w_trialOk ? w_trial[WIDTH-1:0] : w_shiftRem[WIDTH-1:0];
    assign w_stepQuo        = {r_quo[WIDTH-2:0], w_trialOk};
    assign w_unusedTrialBit = w_trial[WIDTH];

    // Sign fix-up of the last step's result. This is what gets registered on
    // entry to DONE. Both negate flags are zero in an unsigned build.
    assign w_finalQuo = r_negQuo ? -w_stepQuo : w_stepQuo;
    assign w_finalRem = r_negRem ? -w_stepRem : w_stepRem;

    // Control FSM and datapath. All outputs come from registers, and reset
    // abandons any operation in flight without producing a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_divMag    <= '0;
            r_negQuo    <= 1'b0;
            r_negRem    <= 1'b0;
            r_ovflPend  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_divByZero <= 1'b0;
            r_ovfl      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_count    <= '0;
                        r_rem      <= '0;
                        r_quo      <= w_dividendMag;
                        r_divMag   <= w_divisorMag;
                        r_negQuo   <= w_dividendNeg ^ w_divisorNeg;
                        r_negRem   <= w_dividendNeg;
                        r_ovflPend <= w_overflowCase;
                        if (w_divisorZero) begin
                            r_state     <= DONE;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_quotient  <= ALL_ONES;
                            r_remainder <= dividend;
                            r_divByZero <= 1'b1;
                            r_ovfl      <= 1'b0;
                        end else begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    r_rem   <= w_stepRem;
                    r_quo   <= w_stepQuo;
                    r_count <= r_count + 1'b1;
                    if (r_count == LAST_ITER) begin
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_quotient  <= w_finalQuo;
                        r_remainder <= w_finalRem;
                        r_divByZero <= 1'b0;
                        r_ovfl      <= r_ovflPend;
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_divByZero;
    assign ovfl        = r_ovfl;

endmodule

// File: tb/tb_seq_div16.sv
// tb_seq_div16: directed, self-checking bench for seq_div16.
// The expected values are hand-computed constants. Signed vectors are used
// when SEQ_DIV_SIGNED_EN is defined; otherwise is_signed is shown to be ignored.

`timescale 1ns/1ps

module tb_seq_div16;

    logic        clk;
    logic        rstN;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        isSigned;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        divByZero;
    logic        ovfl;

    int compareCount  = 0;
    int mismatchCount = 0;

    int          latency;
    logic        busyAfterAccept;
    logic [15:0] midRunQuotient;
    logic [15:0] midRunRemainder;
    int          doneCount;
    int          firstDoneLatency;
    logic [15:0] firstQuotient;
    logic [15:0] firstRemainder;

    seq_div16 #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rstN),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .is_signed   (isSigned),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (divByZero),
        .ovfl        (ovfl)
    );

    // 100 MHz free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it when the observed value differs
    // from the expected one.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Issues one request and waits (bounded) for done. The latency is counted
    // in rising edges from the accepting edge, which counts as 1. When
    // waitIdle is set, the task first lets a DONE cycle retire so that start
    // lands in IDLE. It also records busy just after acceptance, and the
    // outputs halfway through RUN.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic sgn,
                                 input logic waitIdle, input string tag);
        if (waitIdle) @(posedge clk);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        isSigned = sgn;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start           = 1'b0;
        busyAfterAccept = busy;
        latency         = 1;
        midRunQuotient  = quotient;
        midRunRemainder = remainder;
        while (!done && latency < 40) begin
            @(posedge clk);
            #1;
            latency++;
            if (latency == 8) begin
                midRunQuotient  = quotient;
                midRunRemainder = remainder;
            end
        end
        checkOutput({tag, "_doneSeen"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        rstN     = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        isSigned = 1'b0;

        // Check the reset state while reset is held.
        repeat (3) @(negedge clk);
        checkOutput("rst_flags",     {28'd0, busy, done, divByZero, ovfl}, 32'd0);
        checkOutput("rst_quotient",  {16'd0, quotient},  32'd0);
        checkOutput("rst_remainder", {16'd0, remainder}, 32'd0);
        @(negedge clk);
        rstN = 1'b1;

        // Basic unsigned division, including its latency.
        applyStimulus(16'd100, 16'd7, 1'b0, 1'b1, "u100_7");
        checkOutput("u100_7_latency", latency, 32'd17);
        checkOutput("u100_7_busy",    {31'd0, busyAfterAccept}, 32'd1);
        checkOutput("u100_7_quo",     {16'd0, quotient},  32'd14);
        checkOutput("u100_7_rem",     {16'd0, remainder}, 32'd2);
        checkOutput("u100_7_dbz",     {31'd0, divByZero}, 32'd0);
        checkOutput("u100_7_ovfl",    {31'd0, ovfl},      32'd0);

        // Extremes: the largest dividend, then the largest divisor.
        applyStimulus(16'hFFFF, 16'd1, 1'b0, 1'b1, "uFFFF_1");
        checkOutput("uFFFF_1_quo", {16'd0, quotient},  32'h0000FFFF);
        checkOutput("uFFFF_1_rem", {16'd0, remainder}, 32'd0);

        applyStimulus(16'd5, 16'hFFFF, 1'b0, 1'b1, "u5_FFFF");
        checkOutput("u5_FFFF_midQuo", {16'd0, midRunQuotient},  32'h0000FFFF);
        checkOutput("u5_FFFF_midRem", {16'd0, midRunRemainder}, 32'd0);
        checkOutput("u5_FFFF_quo",    {16'd0, quotient},  32'd0);
        checkOutput("u5_FFFF_rem",    {16'd0, remainder}, 32'd5);

        // Divide by zero: done one cycle after start, with the fixed result.
        applyStimulus(16'd1234, 16'd0, 1'b0, 1'b1, "u1234_0");
        checkOutput("u1234_0_latency", latency, 32'd1);
        checkOutput("u1234_0_busy",    {31'd0, busyAfterAccept}, 32'd0);
        checkOutput("u1234_0_quo",     {16'd0, quotient},  32'h0000FFFF);
        checkOutput("u1234_0_rem",     {16'd0, remainder}, 32'd1234);
        checkOutput("u1234_0_dbz",     {31'd0, divByZero}, 32'd1);
        checkOutput("u1234_0_ovfl",    {31'd0, ovfl},      32'd0);

        // The results stay put after done drops.
        repeat (5) @(negedge clk);
        checkOutput("hold_done", {31'd0, done},      32'd0);
        checkOutput("hold_quo",  {16'd0, quotient},  32'h0000FFFF);
        checkOutput("hold_rem",  {16'd0, remainder}, 32'd1234);
        checkOutput("hold_dbz",  {31'd0, divByZero}, 32'd1);

        // A second start three cycles into RUN must be ignored.
        @(negedge clk);
        dividend = 16'd200;
        divisor  = 16'd9;
        isSigned = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start            = 1'b0;
        latency          = 1;
        doneCount        = 0;
        firstDoneLatency = 0;
        firstQuotient    = '0;
        firstRemainder   = '0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c == 2) begin
                dividend = 16'd50;
                divisor  = 16'd5;
                start    = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            latency++;
            if (done) begin
                doneCount++;
                if (doneCount == 1) begin
                    firstDoneLatency = latency;
                    firstQuotient    = quotient;
                    firstRemainder   = remainder;
                end
            end
        end
        checkOutput("reign_doneCount", doneCount, 32'd1);
        checkOutput("reign_latency",   firstDoneLatency, 32'd17);
        checkOutput("reign_quo",       {16'd0, firstQuotient},  32'd22);
        checkOutput("reign_rem",       {16'd0, firstRemainder}, 32'd2);

        // Reset at iteration 8 abandons the operation.
        @(negedge clk);
        dividend = 16'd1000;
        divisor  = 16'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("midrst_flags", {28'd0, busy, done, divByZero, ovfl}, 32'd0);
        checkOutput("midrst_quo",   {16'd0, quotient},  32'd0);
        checkOutput("midrst_rem",   {16'd0, remainder}, 32'd0);
        doneCount = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (done) doneCount++;
        end
        checkOutput("midrst_noDone", doneCount, 32'd0);
        @(posedge clk);
        #2;
        rstN = 1'b1;

        // A request on the first edge after release completes normally.
        applyStimulus(16'd1000, 16'd3, 1'b0, 1'b0, "postrst");
        checkOutput("postrst_latency", latency, 32'd17);
        checkOutput("postrst_quo",     {16'd0, quotient},  32'd333);
        checkOutput("postrst_rem",     {16'd0, remainder}, 32'd1);

`ifdef SEQ_DIV_SIGNED_EN
        // Signed mode: the quotient takes the XOR of the operand signs, and
        // the remainder takes the dividend's sign.
        applyStimulus(16'hFFF9, 16'd2, 1'b1, 1'b1, "sNeg7_2");
        checkOutput("sNeg7_2_quo",  {16'd0, quotient},  32'h0000FFFD);
        checkOutput("sNeg7_2_rem",  {16'd0, remainder}, 32'h0000FFFF);
        checkOutput("sNeg7_2_ovfl", {31'd0, ovfl},      32'd0);

        applyStimulus(16'd7, 16'hFFFE, 1'b1, 1'b1, "s7_neg2");
        checkOutput("s7_neg2_quo", {16'd0, quotient},  32'h0000FFFD);
        checkOutput("s7_neg2_rem", {16'd0, remainder}, 32'd1);

        applyStimulus(16'h8000, 16'hFFFF, 1'b1, 1'b1, "sOvfl");
        checkOutput("sOvfl_quo",  {16'd0, quotient},  32'h00008000);
        checkOutput("sOvfl_rem",  {16'd0, remainder}, 32'd0);
        checkOutput("sOvfl_ovfl", {31'd0, ovfl},      32'd1);

        applyStimulus(16'hFFF9, 16'd0, 1'b1, 1'b1, "sZero");
        checkOutput("sZero_quo",  {16'd0, quotient},  32'h0000FFFF);
        checkOutput("sZero_rem",  {16'd0, remainder}, 32'h0000FFF9);
        checkOutput("sZero_dbz",  {31'd0, divByZero}, 32'd1);
        checkOutput("sZero_ovfl", {31'd0, ovfl},      32'd0);
`else
        // Unsigned-only build: is_signed has no effect.
        applyStimulus(16'hFFF9, 16'd2, 1'b1, 1'b1, "nsFFF9_2");
        checkOutput("nsFFF9_2_quo",  {16'd0, quotient},  32'h00007FFC);
        checkOutput("nsFFF9_2_rem",  {16'd0, remainder}, 32'd1);
        checkOutput("nsFFF9_2_ovfl", {31'd0, ovfl},      32'd0);

        applyStimulus(16'h8000, 16'hFFFF, 1'b1, 1'b1, "ns8000_FFFF");
        checkOutput("ns8000_FFFF_quo",  {16'd0, quotient},  32'd0);
        checkOutput("ns8000_FFFF_rem",  {16'd0, remainder}, 32'h00008000);
        checkOutput("ns8000_FFFF_ovfl", {31'd0, ovfl},      32'd0);
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/seq_div16.md
SEQ_DIV16 -- requirements
Module: seq_div16

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width; only 16 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request a division; sampled on the clk rising edge.
REQ-005 SHALL have port dividend  input  16  numerator; captured on the accepting edge.
REQ-006 SHALL have port divisor  input  16  denominator; captured on the accepting edge.
REQ-007 SHALL have port is_signed  input  1  two's-complement mode select; captured on the accepting edge.
REQ-008 SHALL have port busy  output  1  high while state is RUN.
REQ-009 SHALL have port done  output  1  one-cycle pulse; results valid.
REQ-010 SHALL have port quotient  output  16  result quotient.
REQ-011 SHALL have port remainder  output  16  result remainder.
REQ-012 SHALL have port div_by_zero  output  1  divisor was zero for the last result.
REQ-013 SHALL have port ovfl  output  1  signed overflow for the last result.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN and DONE, with IDLE as the reset state.
REQ-015 SHALL accept start only in IDLE; start in RUN or DONE is ignored, with no queuing.
REQ-016 SHALL, on the accepting edge T0, latch the operands, clear the 5-bit iteration counter and enter RUN.
REQ-017 SHALL, when the captured divisor is 0, enter DONE at T0 instead of RUN, then drive quotient=16'hFFFF, remainder=dividend, div_by_zero=1 and ovfl=0.
REQ-018 SHALL, in RUN, perform one restoring step per edge: shift {rem,quo} left 1; trial = rem - divisor_mag (17-bit); if trial is non-negative, rem=trial and quo[0]=1.
REQ-019 SHALL leave RUN for DONE on edge T16, after exactly 16 iterations.
REQ-020 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE on the next edge.
REQ-021 SHALL have a latency from start to done of 17 cycles for a non-zero divisor and 1 cycle for a zero divisor.
REQ-022 SHALL hold quotient, remainder, div_by_zero and ovfl stable from DONE until the next accepted start.
REQ-023 SHALL update quotient and remainder only on entry to DONE.
REQ-024 SHALL, in unsigned mode, satisfy dividend = quotient*divisor + remainder, with remainder < divisor.

Reset
REQ-025 SHALL, on rst_n low and asynchronously, force state to IDLE.
REQ-026 SHALL, on rst_n low, clear the counter and drive busy=0, done=0, quotient=0, remainder=0, div_by_zero=0 and ovfl=0.
REQ-027 SHALL, on reset mid-RUN, abandon the operation, produce no done pulse, and be ready to accept start on the first edge after rst_n rises.

Configuration
REQ-028 SHALL, with SEQ_DIV_SIGNED_EN defined, honour is_signed=1 using magnitude division.
REQ-029 SHALL, in signed mode, set the quotient sign to dividend sign XOR divisor sign, and the remainder sign to the dividend sign.
REQ-030 SHALL, in signed mode, give the result quotient=16'h8000, remainder=0, ovfl=1 for 16'h8000 / 16'hFFFF.
REQ-031 SHALL, in signed mode with a zero divisor, give quotient=16'hFFFF, remainder=dividend, div_by_zero=1.
REQ-032 SHALL, without SEQ_DIV_SIGNED_EN, ignore is_signed, perform only unsigned division, and tie ovfl to 0; the port list is unchanged.

Verification
REQ-033 SHALL cover: unsigned 100/7 -> done 17 cycles after start; quotient=14, remainder=2, div_by_zero=0.
REQ-034 SHALL cover: 16'hFFFF/1 -> quotient=16'hFFFF, remainder=0; then 5/16'hFFFF -> quotient=0, remainder=5.
REQ-035 SHALL cover: 1234/0 -> done 1 cycle after start; quotient=16'hFFFF, remainder=1234, div_by_zero=1.
REQ-036 SHALL cover: start pulsed again 3 cycles into RUN -> ignored; one done pulse only, and the first operation's results are returned.
REQ-037 SHALL cover: rst_n low at iteration 8 -> all outputs 0, IDLE, no done; a new start after release completes normally.
REQ-038 SHALL cover, with SEQ_DIV_SIGNED_EN: -7/2 -> quotient=-3, remainder=-1; 16'h8000/16'hFFFF -> quotient=16'h8000, ovfl=1.
